fifo_wr_ctrl: RTL and testbench

//  Write-side controller for the switch's clock-domain-crossing frame FIFOs.
//  - Owns the binary write pointer, which feeds the gray-coding pointer data_synchronizer.
//  - Consumes the read pointer returned by the opposite synchronizer (already binary, already in this domain).
//  - Gates writes, generates RAM write strobes/addresses and full/almost-full/level status.
//  - Sequences post-reset settling and flush/drain. Lives entirely in the write clock domain.

---
 rtl/fifo_wr_ctrl_pkg.sv | 14 +
 rtl/fifo_wr_ctrl_if.sv | 14 +
 rtl/fifo_wr_ctrl.sv | 96 +++++++++
 tb/tb_fifo_wr_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_ctrl_pkg.sv
// fifo_pkg: shared state type, pointer sizing and synchronizer latency for the FIFO write side
package fifo_pkg;

    typedef enum logic [1:0] {INIT, RUN, DRAIN} wr_state_t;

    // Two-flop gray synchronizer plus output register on the returning read pointer
    localparam int SYNC_LATENCY = 3;

    // One extra pointer bit beyond the RAM address distinguishes full from empty
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// fifo_wr_ctrl_if: write request handshake and RAM write port of the FIFO write side
interface fifo_wr_ctrl_if #(
    parameter int ADDR_WIDTH = 4
);

    logic                  wr_valid;
    logic                  wr_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;

    modport master (output wr_valid, input wr_ready, input mem_we, input mem_waddr);
    modport slave  (input wr_valid, output wr_ready, output mem_we, output mem_waddr);

endinterface

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-domain pointer, status, error and flush sequencing for a CDC frame FIFO
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH      = 4,
    parameter int ALMOST_FULL_THR = 2,
    parameter int INIT_CYCLES     = 4
) (
    input  logic                clk,
    input  logic                rstn,
    fifo_wr_ctrl_if.slave       wr,
    output logic [ADDR_WIDTH:0] wr_ptr,
    input  logic [ADDR_WIDTH:0] rd_ptr_sync,
    output logic                full,
    output logic                almost_full,
    output logic [ADDR_WIDTH:0] fill_level,
    input  logic                flush_req,
    output logic                flush_done,
    input  logic                clear_err,
    output logic                overflow,
    output logic                ptr_err
);

    localparam int PW     = ptr_width(ADDR_WIDTH);
    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    // Settling must cover the read pointer crossing back, whatever the parameter says
    localparam int INIT_N = (INIT_CYCLES < SYNC_LATENCY) ? SYNC_LATENCY : INIT_CYCLES;
    localparam int CW     = $clog2(INIT_N + 1);

    wr_state_t     state;
    logic [CW-1:0] init_cnt;
    logic [PW-1:0] free_slots;
    logic          accept;

    // Status is derived only from the registered write pointer and the synchronized read pointer
    assign fill_level  = wr_ptr - rd_ptr_sync;
    assign free_slots  = PW'(DEPTH) - fill_level;
    assign full        = (wr_ptr[PW-1] != rd_ptr_sync[PW-1]) &&
                         (wr_ptr[PW-2:0] == rd_ptr_sync[PW-2:0]);
    assign almost_full = free_slots <= PW'(ALMOST_FULL_THR);

    assign wr.wr_ready  = (state == RUN) && !full && !flush_req;
    assign accept       = wr.wr_valid && wr.wr_ready;
    assign wr.mem_we    = accept;
    assign wr.mem_waddr = wr_ptr[PW-2:0];

    // Sequencer: post-reset settling, then run, with flush holding writes off until the reader drains
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= INIT;
            init_cnt   <= '0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                INIT: begin
                    if (init_cnt == CW'(INIT_N - 1))
                        state <= RUN;
                    else
                        init_cnt <= init_cnt + CW'(1);
                end
                RUN: begin
                    if (flush_req)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (fill_level == '0) begin
                        state      <= RUN;
                        flush_done <= 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    // Write pointer advances by exactly one per accepted word so the gray crossing flips a single bit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            wr_ptr <= '0;
        else if (accept)
            wr_ptr <= wr_ptr + PW'(1);
    end

    // Sticky error flags; a fresh set outranks a same-cycle clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow <= 1'b0;
            ptr_err  <= 1'b0;
        end else begin
            overflow <= (wr.wr_valid && full && (state == RUN)) || (overflow && !clear_err);
            ptr_err  <= (fill_level > PW'(DEPTH)) || (ptr_err && !clear_err);
        end
    end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: directed vectors for the FIFO write-side controller
module tb_fifo_wr_ctrl;

    logic       clk         = 1'b0;
    logic       rstn        = 1'b0;
    logic       flush_req   = 1'b0;
    logic       clear_err   = 1'b0;
    logic [4:0] rd_ptr_sync = '0;
    logic [4:0] wr_ptr;
    logic [4:0] fill_level;
    logic       full;
    logic       almost_full;
    logic       flush_done;
    logic       overflow;
    logic       ptr_err;
    int         vectors     = 0;
    int         miscompares = 0;

    fifo_wr_ctrl_if #(.ADDR_WIDTH(4)) bus ();

    fifo_wr_ctrl #(
        .ADDR_WIDTH(4),
        .ALMOST_FULL_THR(2),
        .INIT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .wr(bus),
        .wr_ptr(wr_ptr),
        .rd_ptr_sync(rd_ptr_sync),
        .full(full),
        .almost_full(almost_full),
        .fill_level(fill_level),
        .flush_req(flush_req),
        .flush_done(flush_done),
        .clear_err(clear_err),
        .overflow(overflow),
        .ptr_err(ptr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] prev;
        logic [4:0] d;
        logic [4:0] h [3];
        int         acc;
        int         cyc;
        int         bad;
        int         pulses;
        logic       wrapped;

        // Reset state with a pending request already presented
        bus.wr_valid = 1'b1;
        tick();
        tick();
        chk("rst_ready", bus.wr_ready, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_ptr", wr_ptr, 0);
        chk("rst_done", flush_done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_perr", ptr_err, 0);

        // 1: four settling cycles, then the first write at address 0
        rstn = 1'b1;
        #1;
        for (int c = 1; c <= 4; c++) begin
            chk("init_ready", bus.wr_ready, 0);
            chk("init_we", bus.mem_we, 0);
            tick();
        end
        chk("first_we", bus.mem_we, 1);
        chk("first_addr", bus.mem_waddr, 0);
        tick();
        chk("first_ptr", wr_ptr, 1);

        // 2: fill to 16 against a stalled reader
        for (int i = 1; i <= 15; i++) begin
            chk("af_level", almost_full, (i >= 14) ? 1 : 0);
            chk("fill_ready", bus.wr_ready, 1);
            tick();
        end
        chk("full_ptr", wr_ptr, 16);
        chk("full_flag", full, 1);
        chk("full_af", almost_full, 1);
        chk("full_level", fill_level, 16);
        chk("full_ready", bus.wr_ready, 0);
        chk("full_we", bus.mem_we, 0);
        tick();
        chk("ovf_set", overflow, 1);
        chk("ovf_ptr_held", wr_ptr, 16);
        clear_err = 1'b1;
        tick();
        chk("ovf_set_wins", overflow, 1);
        bus.wr_valid = 1'b0;
        tick();
        chk("ovf_cleared", overflow, 0);
        clear_err = 1'b0;

        // 3: one read frees one slot at address 0
        rd_ptr_sync  = 5'd1;
        bus.wr_valid = 1'b1;
        #1;
        chk("free_full", full, 0);
        chk("free_ready", bus.wr_ready, 1);
        chk("free_we", bus.mem_we, 1);
        chk("free_addr", bus.mem_waddr, 0);
        tick();
        bus.wr_valid = 1'b0;
        #1;
        chk("free_ptr", wr_ptr, 17);
        chk("refull", full, 1);

        // 4: 40 writes chased by a lagging reader, crossing the pointer wrap
        rd_ptr_sync = 5'd17;
        #1;
        chk("chase_empty", fill_level, 0);
        h[0] = 5'd17;
        h[1] = 5'd17;
        h[2] = 5'd17;
        acc = 0;
        cyc = 0;
        bad = 0;
        wrapped = 1'b0;
        bus.wr_valid = 1'b1;
        #1;
        while (acc < 40 && cyc < 200) begin
            prev = wr_ptr;
            if (bus.mem_we) acc++;
            tick();
            cyc++;
            d = wr_ptr - prev;
            if (d > 5'd1) bad++;
            if (prev == 5'd31 && wr_ptr == 5'd0) wrapped = 1'b1;
            h[2] = h[1];
            h[1] = h[0];
            h[0] = prev;
            rd_ptr_sync = h[2];
            #1;
        end
        bus.wr_valid = 1'b0;
        #1;
        chk("chase_accepts", acc, 40);
        chk("chase_step", bad, 0);
        chk("chase_wrap", wrapped, 1);
        chk("chase_ptr", wr_ptr, 25);
        chk("chase_ovf", overflow, 0);
        chk("chase_perr", ptr_err, 0);

        // 5: flush at level 5, reader drains one word per cycle
        rd_ptr_sync  = 5'd25;
        bus.wr_valid = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) tick();
        flush_req = 1'b1;
        #1;
        chk("flush_level", fill_level, 5);
        chk("flush_ready", bus.wr_ready, 0);
        chk("flush_we", bus.mem_we, 0);
        tick();
        flush_req = 1'b0;
        #1;
        pulses = 0;
        for (int i = 1; i <= 5; i++) begin
            chk("drain_ready", bus.wr_ready, 0);
            chk("drain_we", bus.mem_we, 0);
            pulses += int'(flush_done);
            tick();
            rd_ptr_sync = 5'(25 + i);
            #1;
        end
        pulses += int'(flush_done);
        chk("drain_empty_ready", bus.wr_ready, 0);
        tick();
        bus.wr_valid = 1'b0;
        #1;
        chk("flush_done", flush_done, 1);
        chk("resume_ready", bus.wr_ready, 1);
        pulses += int'(flush_done);
        tick();
        pulses += int'(flush_done);
        chk("flush_pulses", pulses, 1);
        chk("flush_ptr", wr_ptr, 30);

        // 6: illegal pointer relation sets a sticky ptr_err
        rd_ptr_sync = 5'd1;
        #1;
        chk("bad_level", fill_level, 29);
        chk("perr_pre", ptr_err, 0);
        tick();
        chk("perr_set", ptr_err, 1);
        chk("perr_ptr", wr_ptr, 30);
        rd_ptr_sync = 5'd30;
        tick();
        chk("perr_sticky", ptr_err, 1);
        rd_ptr_sync = 5'd1;
        clear_err = 1'b1;
        tick();
        chk("perr_set_wins", ptr_err, 1);
        rd_ptr_sync = 5'd30;
        tick();
        chk("perr_cleared", ptr_err, 0);
        clear_err = 1'b0;

        // 7: reset during drain returns to settling without a flush_done
        rd_ptr_sync = 5'd28;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        tick();
        chk("drain2_ready", bus.wr_ready, 0);
        rstn = 1'b0;
        #1;
        chk("midrst_ptr", wr_ptr, 0);
        chk("midrst_done", flush_done, 0);
        chk("midrst_ready", bus.wr_ready, 0);
        rd_ptr_sync = 5'd0;
        tick();
        rstn = 1'b1;
        #1;
        pulses = 0;
        for (int c = 1; c <= 4; c++) begin
            chk("reinit_ready", bus.wr_ready, 0);
            pulses += int'(flush_done);
            tick();
        end
        chk("reinit_resume", bus.wr_ready, 1);
        chk("reinit_pulses", pulses, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
